nn_slave_engine: RTL and testbench

Responder at the NN end of `nnIntf`: decodes `sel`/`RW`/`addr` accesses issued by the bus-master side, stores weight and data words in two local memories, and runs a signed fixed-point dot product when a start key is written. Completion is signalled on the level `pushout`, which the master polls during `WaitNN`. Results are read back through the same interface (`SaveMem` path).

---
 rtl/nn_slave_engine_if.sv | 13 +
 rtl/nn_slave_engine.sv | 129 ++++++++++++
 tb/tb_nn_slave_engine.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_slave_engine_if.sv
// Bus between the bus-master side and the NN responder: one access strobe,
// direction, word address, write data, combinational read data and done level.
interface nn_slave_engine_if;
  logic        sel;
  logic        RW;
  logic [19:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        pushout;

  modport master (output sel, RW, addr, din, input dout, pushout);
  modport slave  (input sel, RW, addr, din, output dout, pushout);
endinterface

// File: rtl/nn_slave_engine.sv
// NN responder: register/memory decode plus a signed 16x16 MAC engine that
// accumulates N products, shifts, saturates and posts the result.
module nn_slave_engine #(
  parameter int          WDEPTH = 64,
  parameter int          DDEPTH = 64,
  parameter logic [31:0] GO_KEY = 32'h0000_0ACE
) (
  input logic              clk,
  input logic              reset,
  nn_slave_engine_if.slave bus
);
  localparam int          WA     = $clog2(WDEPTH);
  localparam int          DA     = $clog2(DDEPTH);
  localparam int          IW     = WA + 1;
  localparam logic [19:0] W_BASE = 20'h20000;
  localparam logic [19:0] D_BASE = 20'h40000;
  localparam logic [19:0] W_MASK = ~20'(WDEPTH - 1);
  localparam logic [19:0] D_MASK = ~20'(DDEPTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  state_t state, state_nxt;

  logic [31:0]        wmem [WDEPTH];
  logic [31:0]        dmem [DDEPTH];
  logic [31:0]        cfg;
  logic [31:0]        result;
  logic signed [47:0] acc;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      n_lat;
  logic [IW-1:0]      n_clamp;
  logic [3:0]         sh_lat;
  logic               wr;
  logic               w_hit;
  logic               d_hit;
  logic               go;
  logic signed [15:0] w_op;
  logic signed [15:0] d_op;
  logic signed [31:0] prod;
  logic signed [31:0] final_val;

  function automatic logic signed [47:0] shift_floor(input logic signed [47:0] v,
                                                     input logic [3:0] sh);
    return v >>> sh;
  endfunction

  function automatic logic signed [31:0] sat32(input logic signed [47:0] v);
    if (v > 48'sh0000_7FFF_FFFF) return 32'sh7FFF_FFFF;
    if (v < 48'shFFFF_8000_0000) return 32'sh8000_0000;
    return v[31:0];
  endfunction

  assign wr      = bus.sel && bus.RW && !reset;
  assign w_hit   = (bus.addr & W_MASK) == W_BASE;
  assign d_hit   = (bus.addr & D_MASK) == D_BASE;
  assign go      = wr && (state == IDLE) && (bus.addr == 20'h2) && (bus.din == GO_KEY);
  assign n_clamp = ({1'b0, cfg[7:0]} > 9'(WDEPTH)) ? IW'(WDEPTH) : IW'(cfg[7:0]);

  // MAC operands come straight from the memories at the current index
  assign w_op      = wmem[WA'(idx)][15:0];
  assign d_op      = dmem[DA'(idx)][15:0];
  assign prod      = 32'(w_op) * 32'(d_op);
  assign final_val = sat32(shift_floor(acc, sh_lat));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = (n_clamp == '0) ? FINISH : RUN;
      RUN:     if (idx == n_lat - 1'b1) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cfg    <= '0;
      result <= '0;
      acc    <= '0;
      idx    <= '0;
      n_lat  <= '0;
      sh_lat <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wr && bus.addr == 20'h0) cfg <= bus.din;
          if (go) begin
            acc    <= '0;
            idx    <= '0;
            n_lat  <= n_clamp;
            sh_lat <= cfg[19:16];
          end
        end
        RUN: begin
          acc <= acc + 48'(prod);
          idx <= idx + 1'b1;
        end
        FINISH:  result <= final_val;
        default: ;
      endcase
    end
  end

  // Host writes land only while idle; the result word shares D's top slot
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == IDLE && wr && w_hit) wmem[bus.addr[WA-1:0]] <= bus.din;
      if (state == IDLE && wr && d_hit) dmem[bus.addr[DA-1:0]] <= bus.din;
      else if (state == FINISH)         dmem[DDEPTH-1] <= final_val;
    end
  end

  always_comb begin
    bus.dout = '0;
    if (bus.sel && !bus.RW) begin
      if (bus.addr == 20'h0)      bus.dout = cfg;
      else if (bus.addr == 20'h2) bus.dout = {31'b0, state != IDLE};
      else if (bus.addr == 20'h4) bus.dout = result;
      else if (w_hit)             bus.dout = wmem[bus.addr[WA-1:0]];
      else if (d_hit)             bus.dout = dmem[bus.addr[DA-1:0]];
    end
  end

  assign bus.pushout = (state == IDLE);
endmodule

// File: tb/tb_nn_slave_engine.sv
// Bench for nn_slave_engine: directed scenarios with literal expectations plus
// randomized traffic, all checked against a transaction-level model.
module tb_nn_slave_engine;
  localparam int          WDEPTH = 64;
  localparam int          DDEPTH = 64;
  localparam logic [31:0] GO     = 32'h0000_0ACE;
  localparam logic [19:0] WB     = 20'h20000;
  localparam logic [19:0] DB     = 20'h40000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  nn_slave_engine_if bus();

  nn_slave_engine #(.WDEPTH(WDEPTH), .DDEPTH(DDEPTH), .GO_KEY(GO)) dut (
    .clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Model state: memories, registers, and cycles of busy time remaining
  logic [31:0] m_w [WDEPTH];
  logic [31:0] m_d [DDEPTH];
  logic [31:0] m_cfg = '0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;
  int          busy_left = 0;
  int          m_a;
  int          m_n;

  int          n_cmp = 0;
  int          n_err = 0;
  string       lit_name [128];
  logic [31:0] lit_got [128];
  logic [31:0] lit_exp [128];
  int          lit_wr = 0;
  int          lit_rd = 0;

  function automatic logic [31:0] dot(int n, int sh);
    longint  s = 0;
    shortint a, b;
    for (int k = 0; k < n; k++) begin
      a = shortint'(m_w[k][15:0]);
      b = shortint'(m_d[k % DDEPTH][15:0]);
      s += longint'(a) * longint'(b);
    end
    s = s >>> sh;
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
    return 32'(s);
  endfunction

  function automatic logic [31:0] exp_rd(logic [19:0] addr);
    int a = int'(addr);
    if (a == 0) return m_cfg;
    if (a == 2) return {31'b0, busy_left != 0};
    if (a == 4) return m_res;
    if (a >= 'h20000 && a < 'h20000 + WDEPTH) return m_w[a - 'h20000];
    if (a >= 'h40000 && a < 'h40000 + DDEPTH) return m_d[a - 'h40000];
    return '0;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_cfg = '0;
        m_res = '0;
        busy_left = 0;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          m_res = m_pend;
          m_d[DDEPTH-1] = m_pend;
        end
      end else if (bus.sel && bus.RW) begin
        m_a = int'(bus.addr);
        if (m_a == 0) m_cfg = bus.din;
        else if (m_a == 2 && bus.din == GO) begin
          m_n = (int'(m_cfg[7:0]) > WDEPTH) ? WDEPTH : int'(m_cfg[7:0]);
          m_pend = dot(m_n, int'(m_cfg[19:16]));
          busy_left = m_n + 1;
        end
        else if (m_a >= 'h20000 && m_a < 'h20000 + WDEPTH) m_w[m_a - 'h20000] = bus.din;
        else if (m_a >= 'h40000 && m_a < 'h40000 + DDEPTH) m_d[m_a - 'h40000] = bus.din;
      end
    end
  end

  logic [31:0] exp_dout;
  initial begin
    forever begin
      @(negedge clk);
      n_cmp++;
      if (bus.pushout !== (busy_left == 0)) begin
        n_err++;
        $display("FAIL pushout t=%0t got=%b want=%b", $time, bus.pushout, busy_left == 0);
      end
      exp_dout = (bus.sel && !bus.RW) ? exp_rd(bus.addr) : 32'h0;
      n_cmp++;
      if (bus.dout !== exp_dout) begin
        n_err++;
        $display("FAIL dout t=%0t addr=%h got=%h want=%h", $time, bus.addr, bus.dout, exp_dout);
      end
      while (lit_rd < lit_wr) begin
        n_cmp++;
        if (lit_got[lit_rd] !== lit_exp[lit_rd]) begin
          n_err++;
          $display("FAIL %s got=%h want=%h", lit_name[lit_rd], lit_got[lit_rd], lit_exp[lit_rd]);
        end
        lit_rd++;
      end
    end
  end

  task automatic lit(string nm, logic [31:0] got, logic [31:0] exp);
    lit_name[lit_wr] = nm;
    lit_got[lit_wr]  = got;
    lit_exp[lit_wr]  = exp;
    lit_wr++;
  endtask

  task automatic drive(logic s, logic r, logic [19:0] a, logic [31:0] d);
    @(posedge clk);
    #1;
    bus.sel = s; bus.RW = r; bus.addr = a; bus.din = d;
  endtask

  task automatic wr(logic [19:0] a, logic [31:0] d);
    drive(1'b1, 1'b1, a, d);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 20'h0, 32'h0);
  endtask

  task automatic rd(logic [19:0] a, output logic [31:0] v);
    drive(1'b1, 1'b0, a, 32'h0);
    @(negedge clk);
    v = bus.dout;
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (cnt < 400) begin
      @(negedge clk);
      if (bus.pushout) break;
      cnt++;
    end
  endtask

  task automatic go_count(logic [31:0] key, output int cnt);
    wr(20'h2, key);
    idle();
    wait_idle(cnt);
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return 32'h0000_7FFF;
      2:       return 32'hFFFF_8000;
      default: return $urandom & 32'h0000_000F;
    endcase
  endfunction

  function automatic logic [19:0] rand_mem_addr();
    return ($urandom_range(0, 1) ? WB : DB) + 20'($urandom_range(0, 63));
  endfunction

  function automatic logic [19:0] rand_addr();
    case ($urandom_range(0, 5))
      0:       return 20'h0;
      1:       return 20'h2;
      2:       return 20'h4;
      3:       return rand_mem_addr();
      4:       return WB + 20'($urandom_range(64, 80));
      default: return 20'($urandom);
    endcase
  endfunction

  task automatic rand_cycle();
    logic [19:0] a = rand_addr();
    logic        w = 1'($urandom_range(0, 1));
    logic [31:0] d = (a == 20'h2 && $urandom_range(0, 1) == 1) ? GO : rand_word();
    drive(1'b1, w, a, d);
    @(negedge clk);
  endtask

  logic [31:0] v;
  logic [31:0] dsave;
  logic [31:0] cfgv;
  int          c;

  initial begin
    bus.sel = 1'b0; bus.RW = 1'b0; bus.addr = '0; bus.din = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    lit("rst_pushout", {31'b0, bus.pushout}, 32'h1);
    rd(20'h0, v); lit("rst_cfg", v, 32'h0);
    rd(20'h2, v); lit("rst_status", v, 32'h0);
    rd(20'h4, v); lit("rst_result", v, 32'h0);

    for (int i = 0; i < WDEPTH; i++) wr(WB + 20'(i), $urandom);
    for (int i = 0; i < DDEPTH; i++) wr(DB + 20'(i), $urandom);

    for (int i = 0; i < 4; i++) begin
      wr(WB + 20'(i), 32'(i + 1));
      wr(DB + 20'(i), 32'(i + 5));
    end
    wr(20'h0, 32'h4);
    go_count(GO, c); lit("basic_low_cycles", 32'(c), 32'd5);
    rd(20'h4, v); lit("basic_result", v, 32'd70);
    rd(DB + 20'h3F, v); lit("basic_d63", v, 32'd70);

    for (int i = 0; i < 16; i++) begin
      wr(WB + 20'(i), (i == 0) ? 32'h0000_FFFF : 32'h0);
      wr(DB + 20'(i), (i == 0) ? 32'h3 : 32'h0);
    end
    wr(20'h0, 32'h0002_0010);
    go_count(GO, c); lit("shift_low_cycles", 32'(c), 32'd17);
    rd(20'h4, v); lit("shift_result", v, 32'hFFFF_FFFF);

    for (int i = 0; i < 3; i++) begin
      wr(WB + 20'(i), 32'h7FFF);
      wr(DB + 20'(i), 32'h7FFF);
    end
    wr(20'h0, 32'h3);
    go_count(GO, c); lit("sat_low_cycles", 32'(c), 32'd4);
    rd(20'h4, v); lit("sat_result", v, 32'h7FFF_FFFF);

    go_count(32'h0000_0ACD, c); lit("badkey_low_cycles", 32'(c), 32'd0);

    for (int i = 0; i < 16; i++) begin
      wr(WB + 20'(i), 32'h1);
      wr(DB + 20'(i), 32'h1);
    end
    wr(20'h0, 32'h10);
    wr(20'h2, GO);
    wr(WB, 32'd9);
    wr(20'h0, 32'hFF);
    wr(20'h2, GO);
    rd(20'h2, v); lit("busy_status", v, 32'h1);
    idle();
    wait_idle(c);
    rd(20'h4, v); lit("busy_result", v, 32'd16);
    rd(20'h0, v); lit("busy_cfg", v, 32'h10);
    rd(WB, v); lit("busy_w0", v, 32'h1);

    wr(20'h0, 32'h0);
    go_count(GO, c); lit("n0_low_cycles", 32'(c), 32'd1);
    rd(20'h4, v); lit("n0_result", v, 32'h0);

    wr(20'h0, 32'hFF);
    go_count(GO, c); lit("clamp_low_cycles", 32'(c), 32'd65);

    dsave = m_d[DDEPTH-1];
    for (int i = 0; i < 4; i++) begin
      wr(WB + 20'(i), 32'h2);
      wr(DB + 20'(i), 32'h3);
    end
    wr(20'h0, 32'h4);
    wr(20'h2, GO);
    idle();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    lit("midreset_pushout", {31'b0, bus.pushout}, 32'h1);
    rd(20'h4, v); lit("midreset_result", v, 32'h0);
    rd(DB + 20'h3F, v); lit("midreset_d63", v, dsave);

    for (int it = 0; it < 25; it++) begin
      int nw = $urandom_range(0, 6);
      for (int k = 0; k < nw; k++) wr(rand_mem_addr(), rand_word());
      for (int k = 0; k < 3; k++) rd(rand_addr(), v);
      cfgv = $urandom;
      cfgv[7:0] = (it % 5 == 0) ? 8'($urandom_range(64, 255)) : 8'($urandom_range(0, 40));
      wr(20'h0, cfgv);
      if (it % 4 == 0) wr(20'h2, GO ^ (32'h1 << $urandom_range(0, 31)));
      wr(20'h2, GO);
      c = 0;
      while (c < 400) begin
        rand_cycle();
        if (bus.pushout) break;
        c++;
      end
      lit("rand_run_done", {31'b0, bus.pushout}, 32'h1);
    end

    idle();
    wait_idle(c);
    lit("final_idle", {31'b0, bus.pushout}, 32'h1);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
